// File: rtl/display_timings_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : display_timings_rx                                           |
// | Description : Receive-side display timing recovery. Rebuilds active-area   |
// |               pixel coordinates from a DE/HSYNC/VSYNC stream, measures the |
// |               incoming geometry and reports lock once it is stable.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk_pix     in   pixel clock (only clock)                                |
// |   rstn_i      in   asynchronous active-low reset                           |
// |   de          in   data enable from decoder                                |
// |   hsync       in   horizontal sync, active level H_POL                     |
// |   vsync       in   vertical sync, active level V_POL                       |
// |   de_o        out  de delayed by one cycle, aligned with sx/sy             |
// |   sx, sy      out  active-area coordinates                                 |
// |   hactive     out  latched de-high cycles per line                         |
// |   vactive     out  latched active lines per frame                          |
// |   htotal      out  latched cycles between de rising edges                  |
// |   vtotal      out  latched hsync assertions per frame                      |
// |   frame_start out  one-cycle pulse on each vsync assertion edge            |
// |   locked      out  geometry stable for LOCK_FRAMES frames                  |
// |   err         out  one-cycle pulse on loss of lock or timeout              |
// +----------------------------------------------------------------------------+
module display_timings_rx #(
    parameter int CORDW       = 12,
    parameter int LOCK_FRAMES = 2,
    parameter bit H_POL       = 1'b1,
    parameter bit V_POL       = 1'b1
) (
    input  logic             clk_pix,
    input  logic             rstn_i,
    input  logic             de,
    input  logic             hsync,
    input  logic             vsync,
    output logic             de_o,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic [CORDW-1:0] hactive,
    output logic [CORDW-1:0] vactive,
    output logic [CORDW-1:0] htotal,
    output logic [CORDW-1:0] vtotal,
    output logic             frame_start,
    output logic             locked,
    output logic             err
);

    localparam logic [CORDW-1:0] CMAX   = '1;
    localparam logic [CORDW-1:0] ONE    = 1;
    localparam logic [3:0]       LOCK_N = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        CHECK   = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    state_t state;

    // Registered, polarity-normalised syncs (de_o doubles as registered de).
    logic hs_r;
    logic vs_r;

    logic hs_n;
    logic vs_n;
    logic de_rise;
    logic de_fall;
    logic hs_rise;
    logic vs_edge;

    assign hs_n    = H_POL ? hsync : ~hsync;
    assign vs_n    = V_POL ? vsync : ~vsync;
    assign de_rise = de & ~de_o;
    assign de_fall = ~de & de_o;
    assign hs_rise = hs_n & ~hs_r;
    assign vs_edge = vs_n & ~vs_r;

    // Working measurements for the frame in progress.
    logic [CORDW-1:0] pcnt;      // cycles since last de rising edge
    logic [CORDW-1:0] acnt;      // length of current de-high run
    logic [CORDW-1:0] vact_w;
    logic [CORDW-1:0] vtot_w;
    logic [CORDW-1:0] hact_w;
    logic [CORDW-1:0] htot_w;
    logic             frame_bad;
    logic [3:0]       match_cnt;

    logic       timeout;
    logic       frame_match;
    logic [3:0] mc_next;

    assign timeout     = (pcnt == CMAX);
    assign frame_match = (hact_w == hactive) && (htot_w == htotal) &&
                         (vact_w == vactive) && (vtot_w == vtotal);
    assign mc_next     = (match_cnt == 4'hF) ? match_cnt : match_cnt + 4'd1;

    // Input stage and coordinates. Everything here is computed from the raw
    // inputs against the registered copy, so sx/sy land with de_o.
    always_ff @(posedge clk_pix or negedge rstn_i) begin
        if (!rstn_i) begin
            de_o        <= 1'b0;
            hs_r        <= 1'b0;
            vs_r        <= 1'b0;
            sx          <= '0;
            sy          <= '0;
            frame_start <= 1'b0;
        end else begin
            de_o        <= de;
            hs_r        <= hs_n;
            vs_r        <= vs_n;
            frame_start <= vs_edge;
            if (de_rise) begin
                sx <= '0;
            end else if (de && sx != CMAX) begin
                sx <= sx + ONE;
            end
            // vact_w is zero until the first line of the frame has started.
            if (de_rise) begin
                if (vs_edge || vact_w == '0) begin
                    sy <= '0;
                end else if (sy != CMAX) begin
                    sy <= sy + ONE;
                end
            end
        end
    end

    // Per-frame measurement. The first line sets the reference h values; the
    // first rise of a frame closes a period that spans vblank, so it is never
    // used (vact_w is 0 there).
    always_ff @(posedge clk_pix or negedge rstn_i) begin
        if (!rstn_i) begin
            pcnt      <= '0;
            acnt      <= '0;
            vact_w    <= '0;
            vtot_w    <= '0;
            hact_w    <= '0;
            htot_w    <= '0;
            frame_bad <= 1'b0;
        end else begin
            if (de_rise) begin
                pcnt <= ONE;
            end else if (pcnt != CMAX) begin
                pcnt <= pcnt + ONE;
            end

            if (de_rise) begin
                acnt <= ONE;
            end else if (de && acnt != CMAX) begin
                acnt <= acnt + ONE;
            end

            if (vs_edge) begin
                vact_w    <= de_rise ? ONE : '0;
                vtot_w    <= hs_rise ? ONE : '0;
                hact_w    <= '0;
                htot_w    <= '0;
                frame_bad <= 1'b0;
            end else begin
                if (de_rise) begin
                    if (vact_w != CMAX) begin
                        vact_w <= vact_w + ONE;
                    end
                    if (vact_w == ONE) begin
                        htot_w <= pcnt;
                    end else if (vact_w > ONE && pcnt != htot_w) begin
                        frame_bad <= 1'b1;
                    end
                end
                if (hs_rise && vtot_w != CMAX) begin
                    vtot_w <= vtot_w + ONE;
                end
                if (de_fall) begin
                    if (vact_w == ONE) begin
                        hact_w <= acnt;
                    end else if (vact_w > ONE && acnt != hact_w) begin
                        frame_bad <= 1'b1;
                    end
                end
            end
        end
    end

    // Lock state machine. Timeout outranks a coincident vsync edge.
    always_ff @(posedge clk_pix or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= IDLE;
            match_cnt <= 4'd0;
            locked    <= 1'b0;
            err       <= 1'b0;
            hactive   <= '0;
            vactive   <= '0;
            htotal    <= '0;
            vtotal    <= '0;
        end else begin
            err <= 1'b0;
            if (timeout) begin
                if (state == CHECK || state == LOCKED) begin
                    err <= 1'b1;
                end
                locked <= 1'b0;
                state  <= IDLE;
            end else if (vs_edge) begin
                case (state)
                    IDLE: begin
                        state <= MEASURE;
                    end
                    MEASURE: begin
                        hactive   <= hact_w;
                        vactive   <= vact_w;
                        htotal    <= htot_w;
                        vtotal    <= vtot_w;
                        match_cnt <= 4'd1;
                        if (LOCK_FRAMES == 1 && !frame_bad) begin
                            locked <= 1'b1;
                            state  <= LOCKED;
                        end else begin
                            state <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (frame_match && !frame_bad) begin
                            match_cnt <= mc_next;
                            if (mc_next >= LOCK_N) begin
                                locked <= 1'b1;
                                state  <= LOCKED;
                            end
                        end else begin
                            hactive   <= hact_w;
                            vactive   <= vact_w;
                            htotal    <= htot_w;
                            vtotal    <= vtot_w;
                            match_cnt <= 4'd1;
                        end
                    end
                    LOCKED: begin
                        if (!frame_match || frame_bad) begin
                            locked    <= 1'b0;
                            err       <= 1'b1;
                            hactive   <= hact_w;
                            vactive   <= vact_w;
                            htotal    <= htot_w;
                            vtotal    <= vtot_w;
                            match_cnt <= 4'd1;
                            state     <= CHECK;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end else if (state == LOCKED && de_fall && acnt != hactive) begin
                // Early loss of lock; latched geometry waits for the vsync edge.
                locked <= 1'b0;
                err    <= 1'b1;
                state  <= CHECK;
            end
        end
    end

endmodule
`default_nettype wire
